branch_unit_bp: RTL and testbench
=================================

BRANCH_UNIT_BP -- requirements
Module: branch_unit_bp

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, number of prediction counters (power of two, at least 2).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
REQ-005 SHALL have the following further ports:
- enable  in  1  execute-stage instruction valid
- instr  in  instruction_t  instruction in execute
- pc_in  in  XLEN  PC of the instruction in execute
- op1, op2, op3  in  XLEN  operands (op3 = branch offset)
- pred_taken_in  in  1  prediction that fetch made for this instruction
- fetch_pc  in  XLEN  PC currently being fetched
- pred_taken  out  1  combinational prediction for fetch_pc
- pc_out  out  XLEN  registered resolved next PC
- ret_addr  out  XLEN  registered link address
- redirect  out  1  one-cycle mispredict pulse
- misalign  out  1  one-cycle misaligned-target pulse
- branch_cnt, mispred_cnt  out  32  statistics counters

Function
REQ-006 SHALL register all outputs except pred_taken, giving 1-cycle latency from an enabled edge.
REQ-007 SHALL compute the target as follows:
- JAL: op1
- JALR: (op1+op2) with bit 0 cleared
- conditional branch, taken: pc_in+op3
- otherwise: pc_in+4
- all sums modulo 2^XLEN
REQ-008 SHALL compare BEQ, BNE, BLT and BGE as signed, and BLTU and BGEU as unsigned.
REQ-009 SHALL treat actual_taken as 1 for JAL/JALR, the comparison result for conditional branches, and 0 otherwise.
REQ-010 SHALL, when enabled and the target is aligned, load pc_out with the target and pulse redirect when actual_taken != pred_taken_in.
REQ-011 SHALL load ret_addr with pc_in+4 for JAL/JALR only; otherwise ret_addr holds.
REQ-012 SHALL, when a taken target has bits[1:0] != 0, pulse misalign and hold pc_out and ret_addr, with no redirect, no BHT update and no counter change.
REQ-013 SHALL, when enable is low, hold all state and drive redirect=0 and misalign=0.
REQ-014 SHALL implement the BHT as BHT_ENTRIES 2-bit saturating counters indexed by PC[log2(BHT_ENTRIES)+1:2].
REQ-015 SHALL drive pred_taken from bit 1 of the counter indexed by fetch_pc.
REQ-016 SHALL update the BHT for enabled, aligned conditional branches only: increment when taken (saturate at 3), decrement when not taken (saturate at 0).
REQ-017 SHALL, when fetch_pc and pc_in share an index on an update edge, return the pre-update counter on pred_taken that cycle.
REQ-018 SHALL increment branch_cnt per resolved aligned conditional branch and mispred_cnt per redirect pulse, each saturating at all-ones.

Reset
REQ-019 SHALL on reset set pc_out=RESET_PC, ret_addr=0, redirect=0, misalign=0, both counters 0, and every BHT entry to 01 (weakly not-taken).
REQ-020 SHALL give rst priority over enable; an instruction presented in the reset cycle is discarded.

Structure
REQ-021 SHALL take instruction_t, register_t and the M_* match constants from the shared opcodes package.
REQ-022 SHALL add a 2-bit counter typedef with named values SNT, WNT, WT and ST to the shared opcodes package.
REQ-023 SHALL place the BHT (read port, update port, reset init) in sub-module branch_bht.

Verification
REQ-024 SHALL cover BEQ with op1=5, op2=5, op3=16, pc_in=0x100, pred_taken_in=0 -> next cycle pc_out=0x110, redirect=1, mispred_cnt=1.
REQ-025 SHALL cover BLT with op1=0xFFFFFFFF, op2=1, and BLTU with the same operands, pc_in=0x200, op3=8 -> BLT pc_out=0x208, BLTU pc_out=0x204.
REQ-026 SHALL cover JALR with op1=0x1001, op2=0x2, pc_in=0x40 -> misalign=1, pc_out unchanged; JALR with op1=0x1001, op2=0x3 -> pc_out=0x1004, ret_addr=0x44.
REQ-027 SHALL cover four taken BNEs at pc_in=0x80 -> counter sequence 01->10->11->11, pred_taken for fetch_pc=0x80 goes 1 after the first update.
REQ-028 SHALL cover an enabled JAL asserted together with rst -> pc_out=RESET_PC, all BHT entries read 01, counters 0.
REQ-029 SHALL cover pc_in=0xFFFFFFFC with a non-branch -> pc_out=0x00000000 (wrap), redirect=0 when pred_taken_in=0.

Source files
------------

// File: rtl/branch_unit_bp_pkg.sv
// branch_unit_bp_pkg: shared opcode types, instruction match constants and BHT counter type
package branch_unit_bp_pkg;
  typedef logic [31:0] instruction_t;
  typedef logic [31:0] register_t;
  localparam instruction_t MASK_OP = 32'h0000_007f;
  localparam instruction_t MASK_OPF3 = 32'h0000_707f;
  localparam instruction_t M_JAL = 32'h0000_006f;
  localparam instruction_t M_JALR = 32'h0000_0067;
  localparam instruction_t M_BEQ = 32'h0000_0063;
  localparam instruction_t M_BNE = 32'h0000_1063;
  localparam instruction_t M_BLT = 32'h0000_4063;
  localparam instruction_t M_BGE = 32'h0000_5063;
  localparam instruction_t M_BLTU = 32'h0000_6063;
  localparam instruction_t M_BGEU = 32'h0000_7063;
  typedef enum logic [1:0] {SNT, WNT, WT, ST} bht_ctr_t;
  function automatic bht_ctr_t ctr_next(bht_ctr_t c, logic taken);
    return taken ? (c == ST ? ST : bht_ctr_t'(c + 2'd1)) : (c == SNT ? SNT : bht_ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/branch_unit_bp_bht.sv
// branch_bht: table of 2-bit saturating counters with one read and one update port
module branch_bht
  import branch_unit_bp_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic                       rd_taken,
  input  logic                       upd,
  input  logic [$clog2(ENTRIES)-1:0] upd_idx,
  input  logic                       upd_taken
);
  bht_ctr_t ctr [ENTRIES];
  // prediction reads the registered counter, so a same-index update is seen only next cycle
  always_comb rd_taken = ctr[rd_idx][1];
  // reset every entry to weakly not-taken, otherwise train the resolved entry
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
    else if (upd) ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
  end
endmodule

// File: rtl/branch_unit_bp.sv
// branch_unit_bp: execute-stage branch resolution with bimodal predictor and statistics
module branch_unit_bp
  import branch_unit_bp_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BHT_ENTRIES = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  instruction_t    instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] op3,
  input  logic            pred_taken_in,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] ret_addr,
  output logic            redirect,
  output logic            misalign,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);
  localparam int IW = $clog2(BHT_ENTRIES);
  instruction_t f3;
  logic is_jal, is_jalr, is_beq, is_bne, is_blt, is_bge, is_bltu, is_bgeu, is_br;
  logic eq, lt, ltu, cmp, taken, mis, ok, miss, upd;
  logic [XLEN-1:0] sum, target, link;
  // decode, compare and target selection; misaligned taken targets are dropped entirely
  always_comb begin
    f3 = instr & MASK_OPF3;
    is_jal = (instr & MASK_OP) == M_JAL;
    is_jalr = f3 == M_JALR;
    is_beq = f3 == M_BEQ;
    is_bne = f3 == M_BNE;
    is_blt = f3 == M_BLT;
    is_bge = f3 == M_BGE;
    is_bltu = f3 == M_BLTU;
    is_bgeu = f3 == M_BGEU;
    is_br = is_beq | is_bne | is_blt | is_bge | is_bltu | is_bgeu;
    eq = op1 == op2;
    lt = $signed(op1) < $signed(op2);
    ltu = op1 < op2;
    cmp = is_beq ? eq : is_bne ? !eq : is_blt ? lt : is_bge ? !lt : is_bltu ? ltu : is_bgeu & !ltu;
    taken = is_jal | is_jalr | (is_br & cmp);
    sum = op1 + op2;
    link = pc_in + XLEN'(4);
    target = is_jal ? op1 : is_jalr ? {sum[XLEN-1:1], 1'b0} : taken ? pc_in + op3 : link;
    mis = taken & (target[1:0] != 2'b00);
    ok = enable & !mis;
    miss = ok & (taken != pred_taken_in);
    upd = ok & is_br;
  end
  branch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_pc[IW+1:2]),
    .rd_taken (pred_taken),
    .upd      (upd),
    .upd_idx  (pc_in[IW+1:2]),
    .upd_taken(taken)
  );
  // resolved PC, link, pulses and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out <= RESET_PC;
      ret_addr <= '0;
      redirect <= 1'b0;
      misalign <= 1'b0;
      branch_cnt <= '0;
      mispred_cnt <= '0;
    end else begin
      redirect <= miss;
      misalign <= enable & mis;
      if (ok) pc_out <= target;
      if (ok & (is_jal | is_jalr)) ret_addr <= link;
      if (upd & ~&branch_cnt) branch_cnt <= branch_cnt + 32'd1;
      if (miss & ~&mispred_cnt) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_unit_bp.sv
// tb_branch_unit_bp: directed vectors checked against a behavioural model every cycle
module tb_branch_unit_bp;
  import branch_unit_bp_pkg::*;
  localparam logic [31:0] RPC = 32'h0000_1000;
  typedef enum {K_ADD, K_JAL, K_JALR, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU} kind_e;
  logic clk = 0, rst, enable, pred_taken_in, pred_taken, redirect, misalign;
  instruction_t instr;
  logic [31:0] pc_in, op1, op2, op3, fetch_pc, pc_out, ret_addr, branch_cnt, mispred_cnt;
  kind_e cur_k;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc, m_ra, m_bc, m_mc;
  logic m_redir, m_mis;
  int m_bht [64];

  branch_unit_bp #(.XLEN(32), .BHT_ENTRIES(64), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .instr(instr), .pc_in(pc_in),
    .op1(op1), .op2(op2), .op3(op3), .pred_taken_in(pred_taken_in),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pc_out(pc_out),
    .ret_addr(ret_addr), .redirect(redirect), .misalign(misalign),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic instruction_t enc(kind_e k);
    case (k)
      K_JAL:   return 32'h0080_00ef;
      K_JALR:  return 32'h0000_80e7;
      K_BEQ:   return 32'h00b5_0463;
      K_BNE:   return 32'h00b5_1463;
      K_BLT:   return 32'h00b5_4463;
      K_BGE:   return 32'h00b5_5463;
      K_BLTU:  return 32'h00b5_6463;
      K_BGEU:  return 32'h00b5_7463;
      default: return 32'h00b5_0533;
    endcase
  endfunction

  function automatic bit is_cond(kind_e k);
    return k inside {K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU};
  endfunction

  function automatic bit taken_f(kind_e k, logic [31:0] a, logic [31:0] b);
    case (k)
      K_JAL, K_JALR: return 1;
      K_BEQ:  return a == b;
      K_BNE:  return a != b;
      K_BLT:  return $signed(a) < $signed(b);
      K_BGE:  return $signed(a) >= $signed(b);
      K_BLTU: return a < b;
      K_BGEU: return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] target_f(kind_e k, logic [31:0] pc, logic [31:0] a, logic [31:0] b, logic [31:0] c);
    if (k == K_JAL) return a;
    if (k == K_JALR) return (a + b) & 32'hFFFF_FFFE;
    if (taken_f(k, a, b)) return pc + c;
    return pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= RPC; m_ra <= 0; m_bc <= 0; m_mc <= 0; m_redir <= 0; m_mis <= 0;
      for (int i = 0; i < 64; i++) m_bht[i] <= 1;
    end else begin
      m_redir <= 0;
      m_mis <= 0;
      if (enable) begin
        if (taken_f(cur_k, op1, op2) && target_f(cur_k, pc_in, op1, op2, op3) % 4 != 0) m_mis <= 1;
        else begin
          m_pc <= target_f(cur_k, pc_in, op1, op2, op3);
          if (cur_k == K_JAL || cur_k == K_JALR) m_ra <= pc_in + 32'd4;
          if (taken_f(cur_k, op1, op2) != pred_taken_in) begin
            m_redir <= 1;
            if (m_mc != 32'hFFFF_FFFF) m_mc <= m_mc + 1;
          end
          if (is_cond(cur_k)) begin
            if (m_bc != 32'hFFFF_FFFF) m_bc <= m_bc + 1;
            m_bht[(pc_in / 4) % 64] <= taken_f(cur_k, op1, op2) ? (m_bht[(pc_in / 4) % 64] == 3 ? 3 : m_bht[(pc_in / 4) % 64] + 1)
                                                                 : (m_bht[(pc_in / 4) % 64] == 0 ? 0 : m_bht[(pc_in / 4) % 64] - 1);
          end
        end
      end
    end
  end

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    cmp("pc_out", pc_out, m_pc);
    cmp("ret_addr", ret_addr, m_ra);
    cmp("redirect", 32'(redirect), 32'(m_redir));
    cmp("misalign", 32'(misalign), 32'(m_mis));
    cmp("branch_cnt", branch_cnt, m_bc);
    cmp("mispred_cnt", mispred_cnt, m_mc);
    cmp("pred_taken", 32'(pred_taken), 32'(m_bht[(fetch_pc / 4) % 64] >= 2));
  endtask

  task automatic setin(kind_e k, logic [31:0] pc, logic [31:0] a, logic [31:0] b, logic [31:0] c, bit pt, bit en, logic [31:0] fpc);
    cur_k = k; instr = enc(k); pc_in = pc; op1 = a; op2 = b; op3 = c;
    pred_taken_in = pt; enable = en; fetch_pc = fpc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    #2;
  endtask

  task automatic step(kind_e k, logic [31:0] pc, logic [31:0] a, logic [31:0] b, logic [31:0] c, bit pt, bit en, logic [31:0] fpc);
    setin(k, pc, a, b, c, pt, en, fpc);
    tick();
  endtask

  initial begin
    rst = 1;
    step(K_JAL, 32'h10, 32'h500, 0, 0, 0, 1, 0);
    cmp("rst_pc", pc_out, RPC);
    cmp("rst_ra", ret_addr, 0);
    cmp("rst_bcnt", branch_cnt, 0);
    cmp("rst_mcnt", mispred_cnt, 0);
    rst = 0;
    for (int i = 0; i < 64; i++) begin
      step(K_JAL, 32'h10, 32'h500, 0, 0, 0, 0, 32'(i * 4));
      cmp("bht_init", 32'(pred_taken), 0);
    end
    cmp("idle_pc", pc_out, RPC);
    step(K_BEQ, 32'h100, 5, 5, 16, 0, 1, 32'h100);
    cmp("beq_pc", pc_out, 32'h110);
    cmp("beq_redir", 32'(redirect), 1);
    cmp("beq_mcnt", mispred_cnt, 1);
    cmp("beq_pred", 32'(pred_taken), 1);
    step(K_BLT, 32'h200, 32'hFFFF_FFFF, 1, 8, 1, 1, 0);
    cmp("blt_pc", pc_out, 32'h208);
    cmp("blt_redir", 32'(redirect), 0);
    step(K_BLTU, 32'h200, 32'hFFFF_FFFF, 1, 8, 1, 1, 0);
    cmp("bltu_pc", pc_out, 32'h204);
    cmp("bltu_redir", 32'(redirect), 1);
    step(K_BGE, 32'h200, 32'hFFFF_FFFF, 1, 8, 0, 1, 0);
    cmp("bge_pc", pc_out, 32'h204);
    step(K_BGEU, 32'h200, 32'hFFFF_FFFF, 1, 8, 0, 1, 0);
    cmp("bgeu_pc", pc_out, 32'h208);
    cmp("bcnt4", branch_cnt, 5);
    step(K_JALR, 32'h40, 32'h1001, 2, 0, 1, 1, 0);
    cmp("jalr_mis", 32'(misalign), 1);
    cmp("jalr_mis_pc", pc_out, 32'h208);
    cmp("jalr_mis_ra", ret_addr, 0);
    step(K_JALR, 32'h40, 32'h1001, 3, 0, 1, 1, 0);
    cmp("jalr_pc", pc_out, 32'h1004);
    cmp("jalr_ra", ret_addr, 32'h44);
    setin(K_BNE, 32'h80, 1, 2, 32'h20, 0, 1, 32'h80);
    #1 cmp("bne_pre", 32'(pred_taken), 0);
    tick();
    cmp("bne1_pred", 32'(pred_taken), 1);
    cmp("bne1_pc", pc_out, 32'hA0);
    for (int i = 0; i < 3; i++) step(K_BNE, 32'h80, 1, 2, 32'h20, 1, 1, 32'h80);
    cmp("bne4_pred", 32'(pred_taken), 1);
    step(K_BNE, 32'h80, 1, 1, 32'h20, 1, 1, 32'h80);
    cmp("bne_nt1_pred", 32'(pred_taken), 1);
    step(K_BNE, 32'h80, 1, 1, 32'h20, 1, 1, 32'h80);
    cmp("bne_nt2_pred", 32'(pred_taken), 0);
    step(K_ADD, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 0);
    cmp("wrap_pc", pc_out, 0);
    cmp("wrap_redir", 32'(redirect), 0);
    step(K_ADD, 32'hFFFF_FFFC, 0, 0, 0, 1, 1, 0);
    cmp("add_pt_redir", 32'(redirect), 1);
    step(K_BEQ, 32'h100, 7, 7, 2, 0, 1, 32'h100);
    cmp("beq_mis", 32'(misalign), 1);
    cmp("beq_mis_pc", pc_out, 0);
    step(K_BEQ, 32'h100, 7, 8, 2, 0, 1, 32'h100);
    cmp("beq_nt_pc", pc_out, 32'h104);
    step(K_BEQ, 32'h100, 7, 7, 32'h10, 1, 1, 32'h100);
    cmp("beq2_pred", 32'(pred_taken), 1);
    step(K_JAL, 32'h300, 32'h400, 0, 0, 0, 1, 32'h100);
    cmp("jal_pc", pc_out, 32'h400);
    cmp("jal_ra", ret_addr, 32'h304);
    step(K_JAL, 32'h300, 32'h800, 0, 0, 0, 0, 32'h100);
    cmp("dis_pc", pc_out, 32'h400);
    cmp("dis_redir", 32'(redirect), 0);
    rst = 1;
    step(K_BEQ, 32'h100, 7, 7, 32'h10, 0, 1, 32'h100);
    rst = 0;
    cmp("rst2_pc", pc_out, RPC);
    cmp("rst2_pred", 32'(pred_taken), 0);
    cmp("rst2_mcnt", mispred_cnt, 0);
    cmp("rst2_ra", ret_addr, 0);
    step(K_ADD, 0, 0, 0, 0, 0, 0, 32'h100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
